// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the LED matrix scanner.
package led_scan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   // Lit cycles per column slot: ((brightness+1)*dwell_cycles) >> bright_bits, 64-bit to avoid overflow.
   function automatic longint unsigned on_cycles_f(
      input longint unsigned brightness,
      input longint unsigned dwell_cycles,
      input longint unsigned bright_bits
   );
      return ((brightness + 64'd1) * dwell_cycles) >> bright_bits;
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder with enable; all zeros when disabled.
module onehot_decoder #(
   parameter int unsigned N = 8
) (
   input  logic [$clog2(N)-1:0] sel,
   input  logic                 en,
   output logic [N-1:0]         onehot_c
);

   // Single bit set at the selected position when enabled.
   always_comb begin
      onehot_c = '0;
      if (en) onehot_c[sel] = 1'b1;
   end

endmodule

// File: rtl/led_matrix_scanner.sv
// Column-scanned NxN LED matrix driver with double-buffered frames and PWM dimming.
module led_matrix_scanner
   import led_scan_pkg::*;
#(
   parameter int unsigned N            = 8,
   parameter int unsigned DWELL_CYCLES = 1024,
   parameter int unsigned BRIGHT_BITS  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic                   frame_valid,
   output logic                   frame_ready,
   input  logic [N*N-1:0]         cells,
   input  logic [BRIGHT_BITS-1:0] brightness,
   output logic [N-1:0]           rows,
   output logic [N-1:0]           cols,
   output logic                   frame_done
);

   localparam int unsigned CW = $clog2(N);
   localparam int unsigned DW = $clog2(DWELL_CYCLES);
   localparam int unsigned OW = $clog2(DWELL_CYCLES + 1);

   scan_state_t    state_q, state_nxt;
   logic [CW-1:0]  col_q, col_nxt;
   logic [DW-1:0]  dwell_q, dwell_nxt;
   logic [OW-1:0]  on_q;
   logic [N*N-1:0] disp_q, pend_q;
   logic           last_slot_c, lit_c, accept_c, swap_c;
   logic [N-1:0]   col_onehot_c, row_drive_c;

   // Pending buffer is full exactly when the producer is being held off.
   assign accept_c = frame_valid & frame_ready;
   assign swap_c   = ~frame_ready & ((state_q == IDLE) | last_slot_c);

   // State and scan counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         dwell_q <= '0;
      end else begin
         state_q <= state_nxt;
         col_q   <= col_nxt;
         dwell_q <= dwell_nxt;
      end
   end

   // Next-state, counter advance and lit-window decode.
   always_comb begin
      state_nxt   = state_q;
      col_nxt     = col_q;
      dwell_nxt   = dwell_q;
      last_slot_c = 1'b0;
      lit_c       = 1'b0;
      case (state_q)
         IDLE: begin
            col_nxt   = '0;
            dwell_nxt = '0;
            if (ena) state_nxt = SCAN;
         end
         SCAN: begin
            if (!ena) begin
               state_nxt = IDLE;
               col_nxt   = '0;
               dwell_nxt = '0;
            end else begin
               last_slot_c = (col_q == CW'(N - 1)) && (dwell_q == DW'(DWELL_CYCLES - 1));
               lit_c       = (dwell_q != '0) && (OW'(dwell_q) <= on_q);
               if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
                  dwell_nxt = '0;
                  col_nxt   = (col_q == CW'(N - 1)) ? '0 : col_q + CW'(1);
               end else begin
                  dwell_nxt = dwell_q + DW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Brightness sampling, frame double-buffer and end-of-scan pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         on_q        <= '0;
         disp_q      <= '0;
         pend_q      <= '0;
         frame_ready <= 1'b1;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= last_slot_c;
         if (dwell_q == '0)
            on_q <= OW'(on_cycles_f(64'(brightness), 64'(DWELL_CYCLES), 64'(BRIGHT_BITS)));
         if (accept_c) begin
            pend_q      <= cells;
            frame_ready <= 1'b0;
         end else if (swap_c) begin
            disp_q      <= pend_q;
            frame_ready <= 1'b1;
         end
      end
   end

   onehot_decoder #(.N(N)) u_col_dec (
      .sel      (col_q),
      .en       (lit_c),
      .onehot_c (col_onehot_c)
   );

   // Active-low row drive for the current column of the display buffer.
   for (genvar r = 0; r < N; r++) begin : g_row
      logic [N-1:0] row_cells;
      assign row_cells      = disp_q[N*r +: N];
      assign row_drive_c[r] = lit_c ? ~row_cells[col_q] : 1'b1;
   end

   // Registered pin drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rows <= '1;
         cols <= '0;
      end else begin
         rows <= row_drive_c;
         cols <= col_onehot_c;
      end
   end

endmodule
